// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: write-back source selects, load funct3 codes,
// write-back FSM states and default datapath widths.
package rv32i_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RA_W_DEF = 5;

    // Write-back result source
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the byte/half/word addressed by addr_lo out of
// the aligned memory word and sign- or zero-extends it per funct3.
// Ports:
//   funct3  - load type (LB/LH/LW/LBU/LHU; others produce 0)
//   addr_lo - load address bits [1:0]
//   rdata   - aligned word containing the target
//   result  - extended load value
module load_align
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        // LH uses only addr_lo[1]; an odd half address is caught upstream
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        result   = '0;
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   result = rdata;
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rf_writeback.sv
// RV32I write-back stage. Drives the register file's single write port.
// Non-load results are written one cycle after acceptance; loads wait for
// the data-memory response (bounded by LD_TIMEOUT cycles), then are aligned
// and extended. Writes to x0 or with we=0 are suppressed.
// Ports:
//   clk, rst            - clock (rising edge), async active-low reset
//   in_valid/in_ready   - retiring instruction handshake
//   in_rd, in_we        - destination register and write flag
//   in_sel              - result source (ALU, LOAD, PC4, IMM)
//   in_alu/pc4/imm      - candidate results
//   in_funct3, in_addr_lo - load type and address low bits
//   mem_rvalid/rready   - load data handshake, mem_rdata the word
//   rf_en, rf_rd, rf_data - registered register-file write port
//   ld_timeout          - one-cycle pulse when a load is abandoned
module rf_writeback
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned RA_W       = RA_W_DEF,
    parameter int unsigned LD_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_we,
    input  logic [1:0]      in_sel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            mem_rready,
    output logic            rf_en,
    output logic [RA_W-1:0] rf_rd,
    output logic [XLEN-1:0] rf_data,
    output logic            ld_timeout
);

    // Abort happens in the last permitted wait cycle, so the stage spends
    // exactly LD_TIMEOUT cycles in LOAD_WAIT.
    localparam logic [7:0] CNT_LAST = 8'(LD_TIMEOUT - 1);

    wb_state_e       state, state_n;
    logic [7:0]      cnt, cnt_n;
    logic [RA_W-1:0] ld_rd, ld_rd_n;
    logic            ld_we, ld_we_n;
    logic [2:0]      ld_f3, ld_f3_n;
    logic [1:0]      ld_lo, ld_lo_n;

    logic            wr_en_n;
    logic [RA_W-1:0] wr_rd_n;
    logic [XLEN-1:0] wr_data_n;
    logic            tmo_n;
    logic [XLEN-1:0] src_data;
    logic [XLEN-1:0] ld_data;

    load_align #(.XLEN(XLEN)) u_align (
        .funct3  (ld_f3),
        .addr_lo (ld_lo),
        .rdata   (mem_rdata),
        .result  (ld_data)
    );

    assign in_ready   = (state == IDLE);
    assign mem_rready = (state == LOAD_WAIT);

    always_comb begin
        case (in_sel)
            WB_PC4:  src_data = in_pc4;
            WB_IMM:  src_data = in_imm;
            default: src_data = in_alu;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ld_rd_n   = ld_rd;
        ld_we_n   = ld_we;
        ld_f3_n   = ld_f3;
        ld_lo_n   = ld_lo;
        wr_en_n   = 1'b0;
        wr_rd_n   = in_rd;
        wr_data_n = src_data;
        tmo_n     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_sel == WB_LOAD) begin
                        ld_rd_n = in_rd;
                        ld_we_n = in_we;
                        ld_f3_n = in_funct3;
                        ld_lo_n = in_addr_lo;
                        cnt_n   = '0;
                        state_n = LOAD_WAIT;
                    end else begin
                        wr_en_n = in_we && (in_rd != '0);
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_rvalid) begin
                    wr_en_n   = ld_we && (ld_rd != '0);
                    wr_rd_n   = ld_rd;
                    wr_data_n = ld_data;
                    state_n   = IDLE;
                end else if (cnt == CNT_LAST) begin
                    tmo_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ld_rd      <= '0;
            ld_we      <= 1'b0;
            ld_f3      <= '0;
            ld_lo      <= '0;
            rf_en      <= 1'b0;
            rf_rd      <= '0;
            rf_data    <= '0;
            ld_timeout <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ld_rd      <= ld_rd_n;
            ld_we      <= ld_we_n;
            ld_f3      <= ld_f3_n;
            ld_lo      <= ld_lo_n;
            rf_en      <= wr_en_n;
            ld_timeout <= tmo_n;
            // Address and data hold their last written values between writes
            if (wr_en_n) begin
                rf_rd   <= wr_rd_n;
                rf_data <= wr_data_n;
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_we;
    logic [1:0]  in_sel;
    logic [31:0] in_alu;
    logic [31:0] in_pc4;
    logic [31:0] in_imm;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rready;
    logic        rf_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        ld_timeout;

    int checks = 0;
    int errors = 0;

    rf_writeback #(.XLEN(32), .RA_W(5), .LD_TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .in_sel     (in_sel),
        .in_alu     (in_alu),
        .in_pc4     (in_pc4),
        .in_imm     (in_imm),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rready (mem_rready),
        .rf_en      (rf_en),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .ld_timeout (ld_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_we = 1'b0; in_sel = 2'b00;
        in_alu = '0; in_pc4 = '0; in_imm = '0; in_funct3 = '0; in_addr_lo = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        checks++;
        if (rf_en !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0 || ld_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b rd=%0d data=%h tmo=%b, want 0 0 00000000 0",
                     rf_en, rf_rd, rf_data, ld_timeout);
        end
        checks++;
        if (in_ready !== 1'b1 || mem_rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got in_ready=%b mem_rready=%b, want 1 0", in_ready, mem_rready);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        in_valid = 1'b1; in_sel = 2'b00; in_rd = 5'd5; in_we = 1'b1; in_alu = 32'h0000_1234;
        tick();
        in_valid = 1'b0;
        checks++;
        if (rf_en !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'h0000_1234 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_write: got en=%b rd=%0d data=%h ready=%b, want 1 5 00001234 1",
                     rf_en, rf_rd, rf_data, in_ready);
        end
        tick();
        checks++;
        if (rf_en !== 1'b0 || rf_rd !== 5'd5 || rf_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL alu_pulse_hold: got en=%b rd=%0d data=%h, want 0 5 00001234",
                     rf_en, rf_rd, rf_data);
        end
    endtask

    task automatic test_suppress();
        in_valid = 1'b1; in_sel = 2'b00; in_rd = 5'd0; in_we = 1'b1; in_alu = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (rf_en !== 1'b0 || rf_data !== 32'h0000_1234 || rf_rd !== 5'd5) begin
            errors++;
            $display("FAIL x0_suppress: got en=%b rd=%0d data=%h, want 0 5 00001234",
                     rf_en, rf_rd, rf_data);
        end
        in_rd = 5'd7; in_we = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (rf_en !== 1'b0 || rf_rd !== 5'd5 || rf_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL we_suppress: got en=%b rd=%0d data=%h, want 0 5 00001234",
                     rf_en, rf_rd, rf_data);
        end
    endtask

    // Accept one load, wait one cycle, respond, check the written value.
    task automatic run_load(input logic [2:0] f3, input logic [1:0] lo,
                            input logic [4:0] rd, input logic [31:0] exp);
        in_valid = 1'b1; in_sel = 2'b01; in_rd = rd; in_we = 1'b1;
        in_funct3 = f3; in_addr_lo = lo;
        tick();
        in_valid = 1'b0; in_funct3 = 3'b111; in_addr_lo = 2'b00;
        checks++;
        if (rf_en !== 1'b0 || in_ready !== 1'b0 || mem_rready !== 1'b1) begin
            errors++;
            $display("FAIL load_accept f3=%b: got en=%b ready=%b rready=%b, want 0 0 1",
                     f3, rf_en, in_ready, mem_rready);
        end
        tick();
        checks++;
        if (rf_en !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_wait f3=%b: got en=%b ready=%b, want 0 0", f3, rf_en, in_ready);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_7F01;
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
        checks++;
        if (rf_en !== 1'b1 || rf_rd !== rd || rf_data !== exp || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_data f3=%b lo=%0d: got en=%b rd=%0d data=%h ready=%b, want 1 %0d %h 1",
                     f3, lo, rf_en, rf_rd, rf_data, in_ready, rd, exp);
        end
    endtask

    task automatic test_load_ext();
        run_load(3'b000, 2'd2, 5'd10, 32'hFFFF_FFFF);
        run_load(3'b100, 2'd3, 5'd11, 32'h0000_0080);
        run_load(3'b001, 2'd2, 5'd12, 32'hFFFF_80FF);
        run_load(3'b101, 2'd0, 5'd13, 32'h0000_7F01);
        run_load(3'b010, 2'd3, 5'd14, 32'h80FF_7F01);
        run_load(3'b001, 2'd3, 5'd15, 32'hFFFF_80FF);
        run_load(3'b011, 2'd0, 5'd16, 32'h0000_0000);
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_we = 1'b1;
        in_sel = 2'b00; in_rd = 5'd1; in_alu = 32'd1;
        tick();
        checks++;
        if (rf_en !== 1'b1 || rf_rd !== 5'd1 || rf_data !== 32'd1) begin
            errors++;
            $display("FAIL b2b_alu: got en=%b rd=%0d data=%h, want 1 1 00000001", rf_en, rf_rd, rf_data);
        end
        in_sel = 2'b10; in_rd = 5'd2; in_pc4 = 32'h0000_0104;
        tick();
        checks++;
        if (rf_en !== 1'b1 || rf_rd !== 5'd2 || rf_data !== 32'h0000_0104) begin
            errors++;
            $display("FAIL b2b_pc4: got en=%b rd=%0d data=%h, want 1 2 00000104", rf_en, rf_rd, rf_data);
        end
        in_sel = 2'b11; in_rd = 5'd3; in_imm = 32'h1234_5000;
        tick();
        checks++;
        if (rf_en !== 1'b1 || rf_rd !== 5'd3 || rf_data !== 32'h1234_5000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_imm: got en=%b rd=%0d data=%h ready=%b, want 1 3 12345000 1",
                     rf_en, rf_rd, rf_data, in_ready);
        end
        in_sel = 2'b01; in_rd = 5'd4; in_funct3 = 3'b010; in_addr_lo = 2'd0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || rf_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load_stall: got ready=%b en=%b, want 0 0", in_ready, rf_en);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (rf_en !== 1'b1 || rf_rd !== 5'd4 || rf_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL b2b_load_done: got en=%b rd=%0d data=%h, want 1 4 cafef00d", rf_en, rf_rd, rf_data);
        end
    endtask

    task automatic test_timeout();
        bit early_bad;
        in_valid = 1'b1; in_sel = 2'b01; in_rd = 5'd9; in_we = 1'b1; in_funct3 = 3'b010;
        tick();
        in_valid = 1'b0;
        early_bad = 1'b0;
        for (int i = 1; i <= 254; i++) begin
            tick();
            if (ld_timeout !== 1'b0 || rf_en !== 1'b0 || in_ready !== 1'b0) early_bad = 1'b1;
        end
        checks++;
        if (early_bad) begin
            errors++;
            $display("FAIL timeout_early: got early abort/write/ready within 254 wait cycles, want none");
        end
        tick();
        checks++;
        if (ld_timeout !== 1'b1 || rf_en !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: got tmo=%b en=%b ready=%b, want 1 0 1", ld_timeout, rf_en, in_ready);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        checks++;
        if (mem_rready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rready: got %b, want 0", mem_rready);
        end
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (ld_timeout !== 1'b0 || rf_en !== 1'b0 || rf_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL late_response: got tmo=%b en=%b data=%h, want 0 0 cafef00d",
                     ld_timeout, rf_en, rf_data);
        end
    endtask

    task automatic test_reset_midload();
        in_valid = 1'b1; in_sel = 2'b01; in_rd = 5'd10; in_we = 1'b1; in_funct3 = 3'b010;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rf_en !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0 || in_ready !== 1'b1 || mem_rready !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset: got en=%b rd=%0d data=%h ready=%b rready=%b, want 0 0 00000000 1 0",
                     rf_en, rf_rd, rf_data, in_ready, mem_rready);
        end
        tick();
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (rf_en !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0 || ld_timeout !== 1'b0) begin
            errors++;
            $display("FAIL midload_response: got en=%b rd=%0d data=%h tmo=%b, want 0 0 00000000 0",
                     rf_en, rf_rd, rf_data, ld_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_suppress();
        test_load_ext();
        test_back_to_back();
        test_timeout();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
